// File: rtl/ene_hit_ctrl_pkg.sv
// Shared definitions for the enemy hit controller.
//  - VGA timing constants (visible area and last counts of line / frame)
//  - FSM state encoding (2 bits)
//  - id_w(): width of an enemy index bus, minimum 1
package ene_hit_ctrl_pkg;

  localparam logic [9:0] H_VIS  = 10'd640;
  localparam logic [9:0] V_VIS  = 10'd480;
  localparam logic [9:0] H_LAST = 10'd799;
  localparam logic [9:0] V_LAST = 10'd524;

  typedef enum logic [1:0] {
    ST_PLAY      = 2'd0,
    ST_HIT       = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_e;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ene_hit_ctrl_overlap_acc.sv
// hit_overlap_acc: per-frame player/enemy overlap accumulator.
//  Ports:
//   clk, rst_n          clock, async active-low reset
//   pixpulse_i          pixel enable
//   hcount_i, vcount_i  current pixel position
//   draw_player_i       player sprite covers pixel
//   draw_ene_i          per-enemy draw strobes
//   clear_i             synchronous clear (game restart)
//   fe_o                frame-end strobe (last pixel of the frame)
//   seen_o              an overlap happened this frame
//   seen_id_o           lowest enemy index of the first overlap this frame
module hit_overlap_acc
  import ene_hit_ctrl_pkg::*;
#(
  parameter int N_ENE = 2,
  parameter int IDW   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pixpulse_i,
  input  logic [9:0]       hcount_i,
  input  logic [9:0]       vcount_i,
  input  logic             draw_player_i,
  input  logic [N_ENE-1:0] draw_ene_i,
  input  logic             clear_i,
  output logic             fe_o,
  output logic             seen_o,
  output logic [IDW-1:0]   seen_id_o
);

  logic           seen_q;
  logic [IDW-1:0] seen_id_q;
  logic [IDW-1:0] first_id;
  logic           vis_ov;

  // Priority encoder: scanning downward leaves the lowest set index.
  always_comb begin
    first_id = '0;
    for (int i = N_ENE - 1; i >= 0; i--)
      if (draw_ene_i[i]) first_id = IDW'(i);
  end

  assign vis_ov = pixpulse_i && (hcount_i < H_VIS) && (vcount_i < V_VIS) &&
                  draw_player_i && (|draw_ene_i);
  assign fe_o   = pixpulse_i && (hcount_i == H_LAST) && (vcount_i == V_LAST);

  // The fe pixel is off-screen, so clearing on fe never drops an overlap;
  // the FSM samples seen_q on that same edge before it clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q    <= 1'b0;
      seen_id_q <= '0;
    end else if (clear_i || fe_o) begin
      seen_q    <= 1'b0;
      seen_id_q <= '0;
    end else if (vis_ov) begin
      seen_q <= 1'b1;
      if (!seen_q) seen_id_q <= first_id;
    end
  end

  assign seen_o    = seen_q;
  assign seen_id_o = seen_id_q;

endmodule

// File: rtl/ene_hit_ctrl.sv
// ene_hit_ctrl: player/enemy collision, lives, invulnerability and game-over.
//  Ports:
//   clk, rst_n          100 MHz clock, async active-low reset
//   pixpulse            pixel enable (1 clk in 4)
//   hcount, vcount      current pixel position
//   draw_player         player sprite covers pixel
//   draw_ene            per-enemy draw strobes
//   restart             1-clk pulse, returns everything to reset values
//   hit                 1-clk pulse when a life is lost
//   hit_id              enemy index of the last hit
//   lives               remaining lives
//   invuln              high while invulnerable after a hit
//   player_show         player visibility (blinks while invulnerable)
//   freeze              high in game over; gates enemy movement
module ene_hit_ctrl
  import ene_hit_ctrl_pkg::*;
#(
  parameter int N_ENE         = 2,
  parameter int START_LIVES   = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int BLINK_FRAMES  = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     pixpulse,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  input  logic                     draw_player,
  input  logic [N_ENE-1:0]         draw_ene,
  input  logic                     restart,
  output logic                     hit,
  output logic [id_w(N_ENE)-1:0]   hit_id,
  output logic [3:0]               lives,
  output logic                     invuln,
  output logic                     player_show,
  output logic                     freeze
);

  localparam int IDW = id_w(N_ENE);

  logic           fe, seen;
  logic [IDW-1:0] seen_id;

  state_e         state_q;
  logic [3:0]     lives_q;
  logic           hit_q, show_q, invuln_q, freeze_q;
  logic [IDW-1:0] hit_id_q;
  logic [7:0]     ifr_q, blk_q;

  hit_overlap_acc #(.N_ENE(N_ENE), .IDW(IDW)) u_acc (
    .clk           (clk),
    .rst_n         (rst_n),
    .pixpulse_i    (pixpulse),
    .hcount_i      (hcount),
    .vcount_i      (vcount),
    .draw_player_i (draw_player),
    .draw_ene_i    (draw_ene),
    .clear_i       (restart),
    .fe_o          (fe),
    .seen_o        (seen),
    .seen_id_o     (seen_id)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_PLAY;
      lives_q  <= 4'(START_LIVES);
      hit_q    <= 1'b0;
      hit_id_q <= '0;
      ifr_q    <= '0;
      blk_q    <= '0;
      show_q   <= 1'b1;
      invuln_q <= 1'b0;
      freeze_q <= 1'b0;
    end else if (restart) begin
      // Wins over a hit landing on the same fe edge.
      state_q  <= ST_PLAY;
      lives_q  <= 4'(START_LIVES);
      hit_q    <= 1'b0;
      hit_id_q <= '0;
      ifr_q    <= '0;
      blk_q    <= '0;
      show_q   <= 1'b1;
      invuln_q <= 1'b0;
      freeze_q <= 1'b0;
    end else begin
      hit_q <= 1'b0;
      if (fe) begin
        unique case (state_q)
          ST_PLAY: begin
            if (seen && lives_q != 4'd0) begin
              hit_q    <= 1'b1;
              hit_id_q <= seen_id;
              lives_q  <= lives_q - 4'd1;
              blk_q    <= '0;
              if (lives_q == 4'd1) begin
                state_q  <= ST_GAME_OVER;
                freeze_q <= 1'b1;
              end else begin
                state_q  <= ST_HIT;
                invuln_q <= 1'b1;
                ifr_q    <= 8'(INVULN_FRAMES);
              end
            end
          end
          ST_HIT: begin
            ifr_q <= ifr_q - 8'd1;
            if (ifr_q == 8'd1) begin
              state_q  <= ST_PLAY;
              invuln_q <= 1'b0;
              show_q   <= 1'b1;
              blk_q    <= '0;
            end else if (blk_q == 8'(BLINK_FRAMES - 1)) begin
              blk_q  <= '0;
              show_q <= ~show_q;
            end else begin
              blk_q <= blk_q + 8'd1;
            end
          end
          ST_GAME_OVER: begin
          end
          default: state_q <= ST_PLAY;
        endcase
      end
    end
  end

  assign hit         = hit_q;
  assign hit_id      = hit_id_q;
  assign lives       = lives_q;
  assign invuln      = invuln_q;
  assign player_show = show_q;
  assign freeze      = freeze_q;

endmodule
